// File: rtl/wb_buffer.sv
// Write-back buffer: a circular FIFO of pending register-file writes drained one per cycle.
// Optional forwarding lookup is compiled in when WB_BUFFER_BYPASS_EN is defined.
module wb_buffer #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              hold,
  output logic [ADDR_W-1:0] write_address,
  output logic [DATA_W-1:0] write_data,
  output logic              write_enable,
  input  logic [ADDR_W-1:0] lk_addr,
  output logic              lk_hit,
  output logic [DATA_W-1:0] lk_data,
  output logic              empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] addr_mem_q [DEPTH];
  logic [ADDR_W-1:0] addr_mem_d [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [DATA_W-1:0] data_mem_d [DEPTH];
  logic [ADDR_W-1:0] wa_q, wa_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic              we_q, we_d;
  logic              push_s;
  logic              pop_s;

  // Readiness depends only on the registered occupancy, never on a same-cycle pop.
  assign in_ready      = (count_q < CNT_W'(DEPTH));
  assign empty         = (count_q == {CNT_W{1'b0}}) && !we_q;
  assign write_address = wa_q;
  assign write_data    = wd_q;
  assign write_enable  = we_q;

  // Writes to register 0 are accepted but dropped, so they never occupy a slot.
  always_comb begin
    push_s = in_valid && in_ready && (in_addr != {ADDR_W{1'b0}});
    pop_s  = (count_q != {CNT_W{1'b0}}) && !hold;
  end

  // Next-state for queue storage, pointers, occupancy and the output stage.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    addr_mem_d = addr_mem_q;
    data_mem_d = data_mem_q;
    wa_d       = wa_q;
    wd_d       = wd_q;
    we_d       = 1'b0;

    if (push_s) begin
      addr_mem_d[tail_q] = in_addr;
      data_mem_d[tail_q] = in_data;
      tail_d             = tail_q + PTR_W'(1);
    end else begin
      tail_d = tail_q;
    end

    if (pop_s) begin
      wa_d   = addr_mem_q[head_q];
      wd_d   = data_mem_q[head_q];
      we_d   = 1'b1;
      head_d = head_q + PTR_W'(1);
    end else begin
      we_d = 1'b0;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards every pending entry and clears the write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= {PTR_W{1'b0}};
      tail_q  <= {PTR_W{1'b0}};
      count_q <= {CNT_W{1'b0}};
      wa_q    <= {ADDR_W{1'b0}};
      wd_q    <= {DATA_W{1'b0}};
      we_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem_q[i] <= {ADDR_W{1'b0}};
        data_mem_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      wa_q       <= wa_d;
      wd_q       <= wd_d;
      we_q       <= we_d;
      addr_mem_q <= addr_mem_d;
      data_mem_q <= data_mem_d;
    end
  end

`ifdef WB_BUFFER_BYPASS_EN
  logic              lk_hit_s;
  logic [DATA_W-1:0] lk_data_s;

  // Newest queued entry wins, then the entry currently on the write port.
  always_comb begin
    lk_hit_s  = 1'b0;
    lk_data_s = {DATA_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      if (!lk_hit_s && (CNT_W'(i) < count_q) &&
          (addr_mem_q[tail_q - PTR_W'(i + 1)] == lk_addr)) begin
        lk_hit_s  = 1'b1;
        lk_data_s = data_mem_q[tail_q - PTR_W'(i + 1)];
      end else begin
        lk_hit_s  = lk_hit_s;
      end
    end
    if (!lk_hit_s && we_q && (wa_q == lk_addr)) begin
      lk_hit_s  = 1'b1;
      lk_data_s = wd_q;
    end else begin
      lk_hit_s  = lk_hit_s;
    end
    if (lk_addr == {ADDR_W{1'b0}}) begin
      lk_hit_s  = 1'b0;
      lk_data_s = {DATA_W{1'b0}};
    end else begin
      lk_hit_s  = lk_hit_s;
    end
  end

  assign lk_hit  = lk_hit_s;
  assign lk_data = lk_data_s;
`else
  logic unused_lk_s;

  assign unused_lk_s = ^lk_addr;
  assign lk_hit      = 1'b0;
  assign lk_data     = {DATA_W{1'b0}};
`endif

endmodule

// File: tb/tb_wb_buffer.sv
// Randomised and directed bench for wb_buffer, checked cycle by cycle against a queue-based model.
module tb_wb_buffer;

  localparam int DATA_W = 24;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic              hold;
  logic [ADDR_W-1:0] write_address;
  logic [DATA_W-1:0] write_data;
  logic              write_enable;
  logic [ADDR_W-1:0] lk_addr;
  logic              lk_hit;
  logic [DATA_W-1:0] lk_data;
  logic              empty;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t              mq[$];
  logic              m_we;
  logic [ADDR_W-1:0] m_wa;
  logic [DATA_W-1:0] m_wd;

  wb_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .hold(hold),
    .write_address(write_address), .write_data(write_data),
    .write_enable(write_enable), .lk_addr(lk_addr), .lk_hit(lk_hit),
    .lk_data(lk_data), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Forwarding reference: newest pending write first, then the write port.
  task automatic model_lk(output logic h, output logic [DATA_W-1:0] d);
    h = 1'b0;
    d = '0;
    if (lk_addr != 0) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (!h && mq[i].a == lk_addr) begin
          h = 1'b1;
          d = mq[i].d;
        end
      end
      if (!h && m_we && m_wa == lk_addr) begin
        h = 1'b1;
        d = m_wd;
      end
    end
  endtask

  task automatic check_outputs(input string ph);
    logic              h;
    logic [DATA_W-1:0] d;
`ifdef WB_BUFFER_BYPASS_EN
    model_lk(h, d);
`else
    h = 1'b0;
    d = '0;
`endif
    check_eq({ph, "_we"},    32'(write_enable),  32'(m_we));
    check_eq({ph, "_wa"},    32'(write_address), 32'(m_wa));
    check_eq({ph, "_wd"},    32'(write_data),    32'(m_wd));
    check_eq({ph, "_rdy"},   32'(in_ready),      32'(mq.size() < DEPTH));
    check_eq({ph, "_empty"}, 32'(empty),         32'(mq.size() == 0 && !m_we));
    check_eq({ph, "_lkhit"}, 32'(lk_hit),        32'(h));
    check_eq({ph, "_lkdat"}, 32'(lk_data),       32'(d));
  endtask

  task automatic tick(input string ph);
    bit   rdy;
    ent_t e;
    @(posedge clk);
    #1;
    rdy = (mq.size() < DEPTH);
    if (mq.size() > 0 && !hold) begin
      e    = mq.pop_front();
      m_we = 1'b1;
      m_wa = e.a;
      m_wd = e.d;
    end else begin
      m_we = 1'b0;
    end
    if (in_valid && rdy && in_addr != 0) begin
      e.a = in_addr;
      e.d = in_data;
      mq.push_back(e);
    end
    check_outputs(ph);
  endtask

  task automatic drive(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                       input logic h, input logic [ADDR_W-1:0] lk);
    in_valid = v;
    in_addr  = a;
    in_data  = d;
    hold     = h;
    lk_addr  = lk;
  endtask

  task automatic do_reset(input string ph);
    rst = 1'b1;
    #1;
    mq.delete();
    m_we = 1'b0;
    m_wa = '0;
    m_wd = '0;
    check_outputs(ph);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 4'd0, 24'h0, 1'b0, 4'd0);
    mq.delete();
    m_we = 1'b0;
    m_wa = '0;
    m_wd = '0;
    #2;
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Single write latency
    drive(1'b1, 4'd3, 24'h00ABCD, 1'b0, 4'd3);
    tick("lat_e1");
    drive(1'b0, 4'd0, 24'h0, 1'b0, 4'd3);
    tick("lat_e2");
    check_eq("lat_we1", 32'(write_enable), 32'd1);
    check_eq("lat_wa", 32'(write_address), 32'd3);
    check_eq("lat_wd", 32'(write_data), 32'h00ABCD);
    tick("lat_e3");
    check_eq("lat_we0", 32'(write_enable), 32'd0);
    check_eq("lat_empty", 32'(empty), 32'd1);

    // Fill while held, reject a fifth offer, then drain in order
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, ADDR_W'(i), DATA_W'(i * 32'h111), 1'b1, 4'd0);
      tick("fill");
    end
    check_eq("full_rdy", 32'(in_ready), 32'd0);
    drive(1'b1, 4'd5, 24'h555, 1'b1, 4'd0);
    tick("fifth");
    drive(1'b0, 4'd0, 24'h0, 1'b0, 4'd0);
    for (int i = 1; i <= 4; i++) begin
      tick("drain");
      check_eq("drain_addr", 32'(write_address), 32'(i));
    end
    tick("drain_end");

    // Forwarding picks the newest write to the same register
    drive(1'b1, 4'd5, 24'h000011, 1'b1, 4'd5);
    tick("fwd1");
    drive(1'b1, 4'd5, 24'h000022, 1'b1, 4'd5);
    tick("fwd2");
    drive(1'b0, 4'd0, 24'h0, 1'b1, 4'd5);
    #1;
`ifdef WB_BUFFER_BYPASS_EN
    check_eq("fwd_hit", 32'(lk_hit), 32'd1);
    check_eq("fwd_data", 32'(lk_data), 32'h000022);
`else
    check_eq("fwd_hit", 32'(lk_hit), 32'd0);
    check_eq("fwd_data", 32'(lk_data), 32'd0);
`endif
    hold = 1'b0;
    for (int i = 0; i < 3; i++) tick("fwd_drain");

    // Register 0 writes vanish
    drive(1'b1, 4'd0, 24'hFFFFFF, 1'b0, 4'd0);
    tick("zero_push");
    check_eq("zero_empty", 32'(empty), 32'd1);
    drive(1'b0, 4'd0, 24'h0, 1'b0, 4'd0);
    tick("zero_after");
    check_eq("zero_we", 32'(write_enable), 32'd0);
    check_eq("zero_lk", 32'(lk_hit), 32'd0);

    // Full queue streaming with pointer wrap
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, ADDR_W'($urandom_range(1, 15)), DATA_W'($urandom), 1'b1, 4'd0);
      tick("wrap_fill");
    end
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, ADDR_W'($urandom_range(1, 15)), DATA_W'($urandom), 1'b0,
            ADDR_W'($urandom_range(0, 15)));
      tick("wrap_run");
    end
    drive(1'b0, 4'd0, 24'h0, 1'b0, 4'd0);
    for (int i = 0; i < 6; i++) tick("wrap_drain");

    // Reset with pending entries
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, ADDR_W'(i + 7), DATA_W'(i + 100), 1'b1, 4'd0);
      tick("prerst");
    end
    do_reset("midrst");
    drive(1'b0, 4'd0, 24'h0, 1'b0, 4'd7);
    for (int i = 0; i < 4; i++) begin
      tick("postrst");
      check_eq("postrst_we", 32'(write_enable), 32'd0);
    end

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 3) != 0), ADDR_W'($urandom_range(0, 15)), DATA_W'($urandom),
            ($urandom_range(0, 2) == 0), ADDR_W'($urandom_range(0, 15)));
      if ($urandom_range(0, 99) == 0) begin
        do_reset("rnd_rst");
      end else begin
        tick("rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
